// File: rtl/core_pkg.sv
// Shared core definitions: the canonical NOP encoding and the fetch/decode
// entry record used by the IF/ID buffer, the ID stage and the hazard unit.
package core_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_entry_t;

endpackage

// File: rtl/perf_counter.sv
// Enable-gated, wrapping 32-bit event counter. Only built when IF_ID_PERF_EN
// is defined, since the IF/ID buffer is its only user.
`ifdef IF_ID_PERF_EN
module perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID decoupling FIFO with valid/ready handshake and EX flush.
// Optional stall/flush event counters are compiled in with IF_ID_PERF_EN.
module if_id_buffer
    import core_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    input  logic              id_ready,
    input  logic              flush
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    if_id_entry_t mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;

    logic push;
    logic pop;

    // Ready depends only on held state, so decode stalls never form a
    // combinational path back into fetch's PC_Write.
    assign if_ready = (count_reg != 2'd2);
    assign id_valid = (count_reg != 2'd0);
    assign id_pc    = mem_reg[rd_ptr_reg].pc;
    assign id_inst  = id_valid ? mem_reg[rd_ptr_reg].inst : NOP_INST;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_reg[i].pc   <= '0;
                mem_reg[i].inst <= NOP_INST;
            end
        end else if (flush) begin
            // Storage is left as-is; only the occupancy is discarded.
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg].pc   <= if_pc;
                mem_reg[wr_ptr_reg].inst <= if_inst;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    perf_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (if_valid & ~if_ready & ~flush),
        .count (perf_stall_cnt)
    );

    perf_counter u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush),
        .count (perf_flush_cnt)
    );
`else
    // Plain buffer: no event counting.
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed vector table, async reset
// sequence, randomized run against a queue model, and optional perf counters.
module tb_if_id_buffer;
    import core_pkg::*;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] IKEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_id_entry_t q[$];
    int unsigned  m_stall = 0;
    int unsigned  m_flush = 0;

    if_id_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .flush    (flush)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // FIFO of at most two entries; flush empties it, full blocks pushes.
    task automatic model_update();
        int sz;
        bit do_pop, do_push;
        if_id_entry_t e;
        sz = q.size();
        if (if_valid && sz == 2 && !flush) m_stall++;
        if (flush) begin
            m_flush++;
            q.delete();
        end else begin
            do_pop  = (sz > 0) && id_ready;
            do_push = if_valid && (sz < 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc = if_pc;
                e.inst = if_inst;
                q.push_back(e);
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ir, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = pc ^ IKEY;
        id_ready = ir;
        flush    = fl;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        m_stall = 0;
        m_flush = 0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_if_ready"}, {31'b0, if_ready}, {31'b0, q.size() < 2});
        chk({tag, "_id_valid"}, {31'b0, id_valid}, {31'b0, q.size() > 0});
        chk({tag, "_id_inst"}, id_inst, (q.size() > 0) ? q[0].inst : NOP);
        if (q.size() > 0) chk({tag, "_id_pc"}, id_pc, q[0].pc);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ir;
        logic        fl;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] exp_inst;

        // streaming
        vecs[0]  = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 1'b1};
        vecs[1]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1};
        vecs[2]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1};
        vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};
        // stall fill, third push ignored, then drain
        vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1};
        vecs[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0};
        vecs[6]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0};
        vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};
        // simultaneous push/pop at count 1
        vecs[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1};
        vecs[10] = '{1'b1, 32'h24, 1'b1, 1'b0, 1'b1, 32'h24, 1'b1};
        // fill, then flush with a concurrent push
        vecs[11] = '{1'b1, 32'h28, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0};
        vecs[12] = '{1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1};
        vecs[13] = '{1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1};
        vecs[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};

        apply_reset();
        chk("reset_if_ready", {31'b0, if_ready}, 32'd1);
        chk("reset_id_valid", {31'b0, id_valid}, 32'd0);
        chk("reset_id_pc", id_pc, 32'h0);
        chk("reset_id_inst", id_inst, NOP);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].ir, vecs[i].fl);
            step();
            exp_inst = vecs[i].exp_valid ? (vecs[i].exp_pc ^ IKEY) : NOP;
            chk($sformatf("vec%0d_id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_id_inst", i), id_inst, exp_inst);
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].exp_pc);
            $display("vec %0d pc=%08h v=%0b ir=%0b fl=%0b -> id_valid=%0b id_pc=%08h if_ready=%0b",
                     i, vecs[i].pc, vecs[i].v, vecs[i].ir, vecs[i].fl, id_valid, id_pc, if_ready);
        end

        // async reset while full: outputs clear without a clock edge
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h54, 1'b0, 1'b0);
        step();
        chk("prereset_full", {31'b0, if_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("async_rst_id_inst", id_inst, NOP);
        chk("async_rst_if_ready", {31'b0, if_ready}, 32'd1);
        chk("async_rst_id_pc", id_pc, 32'h0);
        $display("async reset: id_valid=%0b id_inst=%08h if_ready=%0b", id_valid, id_inst, if_ready);
        q.delete();
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        step();
        chk("post_rst_push_valid", {31'b0, id_valid}, 32'd1);
        chk("post_rst_push_pc", id_pc, 32'h0);
        chk("post_rst_push_inst", id_inst, IKEY);
        $display("post-reset push: id_pc=%08h id_inst=%08h", id_pc, id_inst);

        // randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            if_valid = ($urandom_range(0, 9) < 7);
            if_pc    = $urandom() & 32'hFFFF_FFFC;
            if_inst  = $urandom();
            id_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 11) == 0);
            step();
            check_model($sformatf("rnd%0d", n));
            $display("rnd %0d v=%0b ir=%0b fl=%0b -> id_valid=%0b id_pc=%08h if_ready=%0b",
                     n, if_valid, id_ready, flush, id_valid, id_pc, if_ready);
        end
`ifdef IF_ID_PERF_EN
        chk("rnd_perf_stall", perf_stall_cnt, m_stall);
        chk("rnd_perf_flush", perf_flush_cnt, m_flush);

        // directed: 3 stalled cycles while full, then 2 flushes
        apply_reset();
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h108, 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
        $display("perf: stall=%0d flush=%0d", perf_stall_cnt, perf_flush_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
